// File: rtl/ifetch_issue.sv
// Instruction fetch/issue unit for the RISC-Z core. Owns the PC, fetches over a
// req/ack handshake, and issues pre-split decode fields over valid/ready.
module ifetch_issue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [15:0]       instr,
  output logic [3:0]        op,
  output logic              r,
  output logic [1:0]        ls,
  output logic [1:0]        ad,
  output logic [ADDR_W-1:0] pc_out,
  output logic              illegal,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int unsigned INSTR_W = 16;
  localparam logic [3:0]  OP_HALT = 4'b0000;
  localparam logic [3:0]  OP_LS   = 4'b1110;

  typedef enum logic [1:0] {S_FETCH, S_WAIT_ACK, S_ISSUE, S_HALT} state_t;

  state_t             r_state, w_next_state;
  logic [ADDR_W-1:0]  r_pc, w_next_pc;
  logic [ADDR_W-1:0]  r_addr, w_next_addr;
  logic [INSTR_W-1:0] r_instr, w_next_instr;
  logic               r_flush, w_next_flush;
  logic [INSTR_W-1:0] w_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_instr <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_addr  <= w_next_addr;
      r_instr <= w_next_instr;
      r_flush <= w_next_flush;
    end
  end

  // Redirect beats both the PC increment and the issue handshake.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_addr  = r_addr;
    w_next_instr = r_instr;
    w_next_flush = r_flush;
    case (r_state)
      S_FETCH: begin
        w_next_addr = r_pc;
        if (redirect) w_next_pc = redirect_pc;
        else          w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (redirect) w_next_pc = redirect_pc;
        if (imem_ack) begin
          w_next_flush = 1'b0;
          if (r_flush || redirect) begin
            w_next_state = S_FETCH;
          end else begin
            w_next_instr = imem_rdata;
            w_next_state = S_ISSUE;
          end
        end else if (redirect) begin
          w_next_flush = 1'b1;
        end
      end
      S_ISSUE: begin
        if (redirect) begin
          w_next_pc    = redirect_pc;
          w_next_state = S_FETCH;
        end else if (issue_ready) begin
          if (r_instr[15:12] == OP_HALT) begin
            w_next_state = S_HALT;
          end else begin
            w_next_pc    = r_pc + ADDR_W'(1);
            w_next_state = S_FETCH;
          end
        end
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Outputs show reset values for as long as reset is held, even mid-fetch.
  assign imem_req    = !reset && (r_state == S_FETCH || r_state == S_WAIT_ACK);
  assign imem_addr   = reset ? RESET_PC : ((r_state == S_WAIT_ACK) ? r_addr : r_pc);
  assign issue_valid = !reset && (r_state == S_ISSUE);
  assign halted      = !reset && (r_state == S_HALT);
  assign pc_out      = reset ? RESET_PC : r_pc;
  assign w_instr     = reset ? '0 : r_instr;

  assign instr   = w_instr;
  assign op      = w_instr[15:12];
  assign r       = w_instr[0];
  assign ls      = w_instr[1:0];
  assign ad      = w_instr[1:0];
  assign illegal = (w_instr[15:12] == OP_LS) &&
                   (w_instr[1:0] == 2'b00 || w_instr[1:0] == 2'b11);

endmodule

// File: tb/tb_ifetch_issue.sv
// Bench for ifetch_issue: directed scenarios plus random traffic, checked by a
// scoreboard holding the next expected issue address and an array memory model.
`timescale 1ns/1ps
module tb_ifetch_issue;

  localparam int unsigned AW     = 16;
  localparam logic [15:0] RST_PC = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, issue_valid, r, illegal, halted;
  logic        imem_ack = 1'b0;
  logic        issue_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] imem_addr, instr, pc_out;
  logic [15:0] imem_rdata = 16'h0;
  logic [15:0] redirect_pc = 16'h0;
  logic [3:0]  op;
  logic [1:0]  ls, ad;

  ifetch_issue #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .instr(instr), .op(op), .r(r), .ls(ls), .ad(ad), .pc_out(pc_out), .illegal(illegal),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  initial forever #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          hs_count = 0;
  int          fixed_lat = 1;
  logic [15:0] mem [0:65535];
  logic [15:0] q_exp [$];
  bit          exp_halt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Redirect pulse; the next issued instruction must come from the target.
  task automatic do_redirect(input logic [15:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    q_exp.delete();
    q_exp.push_back(tgt);
  endtask

  task automatic wait_issue(input logic [15:0] pc, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = (issue_valid === 1'b1) && (pc_out === pc);
    end
    chk(name, 32'(seen), 1);
  endtask

  // Memory: acks once the request has been held lat_cur cycles at one address.
  int          wcnt = 0;
  int          lat_cur = 0;
  logic [15:0] last_addr = 16'h0;
  bit          last_req = 1'b0;
  initial forever begin
    @(negedge clk);
    if (imem_req === 1'b1 && last_req && imem_addr == last_addr) begin
      wcnt++;
    end else begin
      wcnt = 0;
      lat_cur = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
    last_req  = (imem_req === 1'b1);
    last_addr = imem_addr;
    if (imem_req === 1'b1 && wcnt >= lat_cur) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[imem_addr];
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
    end
  end

  // Monitor: protocol checks every cycle, scoreboard compare on each handshake.
  bit          prev_hold = 1'b0;
  logic [15:0] prev_pc, prev_instr, m_e, m_w;
  logic [3:0]  m_op;
  logic [1:0]  m_ls;
  bit          m_ill;
  initial forever begin
    @(negedge clk);
    if (reset !== 1'b0) begin
      q_exp.delete();
      q_exp.push_back(RST_PC);
      exp_halt  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("halted", 32'(halted), 32'(exp_halt));
      if (halted === 1'b1) begin
        chk("halt_req", 32'(imem_req), 0);
        chk("halt_valid", 32'(issue_valid), 0);
      end
      if (issue_valid === 1'b1) chk("issue_no_req", 32'(imem_req), 0);
      if (prev_hold) begin
        chk("hold_valid", 32'(issue_valid), 1);
        chk("hold_pc", 32'(pc_out), 32'(prev_pc));
        chk("hold_instr", 32'(instr), 32'(prev_instr));
      end
      prev_hold  = (issue_valid === 1'b1) && !issue_ready && !redirect;
      prev_pc    = pc_out;
      prev_instr = instr;
      if (issue_valid === 1'b1 && issue_ready && !redirect) begin
        hs_count++;
        if (q_exp.size() == 0) begin
          chk("sb_unexpected_issue", 32'(pc_out), 32'hFFFF_FFFF);
        end else begin
          m_e   = q_exp.pop_front();
          m_w   = mem[m_e];
          m_op  = 4'(m_w / 16'd4096);
          m_ls  = 2'(m_w % 16'd4);
          m_ill = (m_op == 4'd14) && (m_ls == 2'd0 || m_ls == 2'd3);
          chk("sb_pc", 32'(pc_out), 32'(m_e));
          chk("sb_instr", 32'(instr), 32'(m_w));
          chk("sb_op", 32'(op), 32'(m_op));
          chk("sb_r", 32'(r), 32'(m_w % 16'd2));
          chk("sb_ls", 32'(ls), 32'(m_ls));
          chk("sb_ad", 32'(ad), 32'(m_ls));
          chk("sb_illegal", 32'(illegal), 32'(m_ill));
          if (m_op == 4'd0) exp_halt = 1'b1;
          else              q_exp.push_back(16'(m_e + 16'd1));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int  gap, hs0;
  bit  seen, bad;
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[16'hFFFF] = 16'hE003;
    mem[16'h0000] = 16'h1123;
    mem[16'h0001] = 16'h2456;
    mem[16'h0002] = 16'hE0A2;
    mem[16'h0003] = 16'h4001;
    mem[16'h0004] = 16'h0000;
    mem[16'h0040] = 16'h5001;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc_out", 32'(pc_out), 32'(RST_PC));
    chk("rst_addr", 32'(imem_addr), 32'(RST_PC));
    chk("rst_op", 32'(op), 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", 32'(imem_addr), 32'(RST_PC));

    // Illegal op at 0xFFFF, then PC wraps to 0
    wait_issue(16'hFFFF, "issue_ffff");
    chk("ill_ffff", 32'(illegal), 1);
    chk("ls_ffff", 32'(ls), 3);
    @(negedge clk);
    chk("wrap_req", 32'(imem_req), 1);
    chk("wrap_addr", 32'(imem_addr), 0);
    gap = 1;
    while (issue_valid !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("cadence", 32'(gap), 3);
    chk("issue_0_pc", 32'(pc_out), 0);

    // Backpressure on 0xE0A2
    wait_issue(16'h0001, "issue_1");
    @(posedge clk); #1 issue_ready = 1'b0;
    wait_issue(16'h0002, "issue_2");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(issue_valid), 1);
      chk("bp_instr", 32'(instr), 'hE0A2);
      chk("bp_ls", 32'(ls), 2);
      chk("bp_pc", 32'(pc_out), 2);
      chk("bp_req", 32'(imem_req), 0);
      chk("bp_illegal", 32'(illegal), 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 issue_ready = 1'b1;

    // HALT at 4; a redirect while halted must be ignored
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = (halted === 1'b1);
    end
    chk("halt_reached", 32'(seen), 1);
    chk("halt_pc", 32'(pc_out), 4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      redirect    = (i == 5);
      redirect_pc = 16'h0010;
      @(negedge clk);
      chk("halt_stays", 32'(imem_req === 1'b0 && halted === 1'b1), 1);
    end

    // Reset in the middle of WAIT_ACK
    @(posedge clk); #1 redirect = 1'b0; fixed_lat = 6; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rw_req", 32'(imem_req), 1);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1; fixed_lat = 4;
    @(negedge clk);
    chk("rst_mid_req", 32'(imem_req), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_req2", 32'(imem_req), 0);
    @(posedge clk); #1 reset = 1'b0; mem[16'hFFFF] = 16'h3000;
    @(negedge clk);
    chk("restart_req", 32'(imem_req), 1);
    chk("restart_addr", 32'(imem_addr), 32'(RST_PC));

    // Redirect during WAIT_ACK: the late 0x3000 must be discarded
    @(posedge clk); #1 do_redirect(16'h0040);
    @(posedge clk); #1 redirect = 1'b0; fixed_lat = 1; issue_ready = 1'b0;
    seen = 1'b0;
    bad  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (issue_valid === 1'b1) bad = 1'b1;
      seen = (imem_req === 1'b1) && (imem_addr !== 16'hFFFF);
    end
    chk("flush_no_issue", 32'(bad), 0);
    chk("flush_addr", seen ? 32'(imem_addr) : 32'hDEAD, 'h0040);
    wait_issue(16'h0040, "issue_40");
    chk("issue_40_instr", 32'(instr), 'h5001);

    // Redirect in ISSUE with issue_ready in the same cycle
    hs0 = hs_count;
    @(posedge clk); #1 do_redirect(16'h0080); issue_ready = 1'b1;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("rd_valid", 32'(issue_valid), 0);
    chk("rd_req", 32'(imem_req), 1);
    chk("rd_addr", 32'(imem_addr), 'h0080);
    chk("rd_no_handshake", 32'(hs_count), 32'(hs0));

    // Random traffic
    @(posedge clk); #1 fixed_lat = -1;
    hs0 = hs_count;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      if (reset) begin
        reset = 1'b0;
      end else if (halted === 1'b1) begin
        if ($urandom_range(0, 2) == 0) reset = 1'b1;
      end else begin
        issue_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) do_redirect(16'($urandom));
      end
    end
    @(negedge clk);
    chk("rand_progress", 32'((hs_count - hs0) >= 200), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_issue.md
# ifetch_issue

Instruction fetch and issue unit for the RISC-Z core. It holds the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and presents the instruction and its pre-split decode fields (op, r, ls, ad) to the control decoder with a valid/ready handshake. It stops on HALT (op 0000) and accepts branch/jump redirects from the execute stage.

## Interface
- ADDR_W, 16, PC / instruction-memory word-address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  ADDR_W  word address of the fetch; stable while imem_req high
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- issue_valid  out  1  instruction fields valid
- issue_ready  in  1  decoder/pipeline accepts the instruction
- instr  out  16  raw instruction
- op  out  4  instr[15:12]
- r  out  1  instr[0]; meaningful only when op = 1001
- ls  out  2  instr[1:0]; meaningful only when op = 1110
- ad  out  2  instr[1:0]; meaningful only when op = 1111
- pc_out  out  ADDR_W  address of the issued instruction
- illegal  out  1  issued instruction is op 1110 with ls ∈ {00, 11}
- redirect  in  1  one-cycle pulse: load PC from redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- halted  out  1  HALT instruction has been issued

## Operation
- FSM states: FETCH, WAIT_ACK, ISSUE, HALT.
- FETCH: assert imem_req with imem_addr = pc; go to WAIT_ACK.
- WAIT_ACK: imem_req held high, imem_addr stable. On imem_ack: if flush flag clear, latch imem_rdata into instr register, go to ISSUE; if flush set, discard data, clear flush, go to FETCH.
- ISSUE: issue_valid = 1; instr, op, r, ls, ad, pc_out, illegal stable until accepted. On issue_valid && issue_ready: if op = 0000 go to HALT (pc unchanged), else pc <= pc + 1 (mod 2^ADDR_W, wraps to 0), go to FETCH.
- HALT: halted = 1, imem_req = 0, issue_valid = 0; only reset leaves HALT; redirect ignored.
- Redirect (pc <= redirect_pc, takes priority over the increment):
  - in FETCH: pc updated, request issued next cycle at redirect_pc.
  - in WAIT_ACK: pc updated, flush flag set (ack same cycle: data discarded, go to FETCH, flush not set).
  - in ISSUE: held instruction dropped (even if issue_ready same cycle — no handshake counted), issue_valid low next cycle, go to FETCH.
- Field outputs are combinational slices of the instr register; illegal computed from the register.

## Timing
- Reset (cycle with reset = 1): pc = RESET_PC, state = FETCH, flush = 0, instr = 0; all outputs 0 (imem_req, imem_addr = RESET_PC excepted only in value, issue_valid, op, r, ls, ad, illegal, halted = 0, pc_out = RESET_PC). Reset mid-fetch abandons the request; a late imem_ack is ignored by the FETCH state.
- First imem_req: first cycle after reset deasserts.
- imem_ack in cycle N → issue_valid in cycle N+1.
- Handshake in cycle M → imem_req in cycle M+1 at pc+1.
- Back-to-back with single-cycle ack: one instruction per 3 cycles.
- issue_valid never deasserts without a handshake except on redirect or reset.

## Test plan
- Sequential fetch: reset, imem returns 0x1123 at 0, 0x2456 at 1, ack 1 cycle after req, issue_ready = 1 → issue op=0001 pc_out=0, then op=0010 pc_out=1; imem_addr 0,1,2.
- Backpressure: issue_ready = 0 for 5 cycles with instr 0xE0A2 → issue_valid, instr, ls=10, pc_out held constant all 5 cycles; no new imem_req; illegal = 0.
- Halt: instr 0x0000 at address 4 accepted → halted = 1 next cycle, imem_req stays 0 for 20 cycles, pc_out = 4.
- Redirect during WAIT_ACK: redirect to 0x0040 while waiting, ack arrives 3 cycles later with 0x3000 → 0x3000 never issued; next imem_addr = 0x0040.
- Redirect in ISSUE with issue_ready = 1 same cycle → instruction not counted, next imem_addr = redirect_pc.
- Illegal/wrap: RESET_PC = 0xFFFF, instr 0xE003 → illegal = 1, ls = 11; after accept imem_addr = 0x0000; reset asserted mid-WAIT_ACK → imem_req low next cycle, restart at RESET_PC.
